// File: rtl/mips_mult_div_pkg.sv
// Shared constants for the multicycle multiply/divide unit and the core decoder.
package mips_mult_div_pkg;

   localparam int unsigned MD_WIDTH = 32;

   // Op codes; the decoder maps funct 0x18/0x19/0x1A/0x1B/0x11/0x13 onto these.
   localparam logic [2:0] MD_OP_MULT  = 3'b000;
   localparam logic [2:0] MD_OP_MULTU = 3'b001;
   localparam logic [2:0] MD_OP_DIV   = 3'b010;
   localparam logic [2:0] MD_OP_DIVU  = 3'b011;
   localparam logic [2:0] MD_OP_MTHI  = 3'b100;
   localparam logic [2:0] MD_OP_MTLO  = 3'b101;

   typedef enum logic [2:0] {
      MD_ST_IDLE = 3'd0,
      MD_ST_PREP = 3'd1,
      MD_ST_RUN  = 3'd2,
      MD_ST_FIX  = 3'd3,
      MD_ST_DONE = 3'd4
   } md_state_e;

   // LO value written on divide by zero (truncated to the operand width).
   localparam logic [63:0] MD_DIVZ_LO = '1;

endpackage

// File: rtl/mips_mult_div.sv
// Multicycle shift-add multiplier / restoring divider with HI/LO registers.
module mips_mult_div
   import mips_mult_div_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             md_in_clk,
   input  logic             md_in_rst,
   input  logic             md_in_start,
   input  logic [2:0]       md_in_op,
   input  logic [WIDTH-1:0] md_in_a,
   input  logic [WIDTH-1:0] md_in_b,
   output logic             md_out_busy,
   output logic             md_out_done,
   output logic [WIDTH-1:0] md_out_hi,
   output logic [WIDTH-1:0] md_out_lo
);

   localparam int unsigned W2    = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [W2-1:0]      work_q, work_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               rsign_q, rsign_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               is_signed;
   logic               is_div;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_top;
   logic [WIDTH-1:0]   div_diff;
   logic [W2-1:0]      prod_fix;

   // Conditional two's-complement negate (abs at PREP, sign restore at FIX).
   function automatic logic [WIDTH-1:0] signfix(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   function automatic logic [W2-1:0] signfix2(input logic [W2-1:0] v, input logic neg);
      return neg ? (~v + W2'(1)) : v;
   endfunction

   assign is_signed = ~op_q[0];
   assign is_div    = op_q[1];

   // State, datapath and output registers; reset clears everything.
   always_ff @(posedge md_in_clk) begin
      if (md_in_rst) begin
         state_q <= MD_ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         rsign_q <= rsign_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, per-cycle multiply/divide step and registered output values.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rsign_d  = rsign_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + {1'b0, (work_q[0] ? b_q : {WIDTH{1'b0}})};
      div_top  = work_q[W2-1:WIDTH-1];
      div_diff = div_top[WIDTH-1:0] - b_q;
      prod_fix = signfix2(work_q, neg_q);

      case (state_q)
         MD_ST_IDLE: begin
            if (md_in_start) begin
               case (md_in_op)
                  MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                     op_d    = md_in_op[1:0];
                     a_d     = md_in_a;
                     b_d     = md_in_b;
                     neg_d   = ~md_in_op[0] & (md_in_a[WIDTH-1] ^ md_in_b[WIDTH-1]);
                     rsign_d = ~md_in_op[0] & md_in_a[WIDTH-1];
                     busy_d  = 1'b1;
                     state_d = MD_ST_PREP;
                  end
                  MD_OP_MTHI: begin
                     hi_d   = md_in_a;
                     done_d = 1'b1;
                  end
                  MD_OP_MTLO: begin
                     lo_d   = md_in_a;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         MD_ST_PREP: begin
            // Magnitude of A goes to the low half (multiplier / dividend), |B| stays in b_q.
            work_d  = {{WIDTH{1'b0}}, signfix(a_q, is_signed & a_q[WIDTH-1])};
            b_d     = signfix(b_q, is_signed & b_q[WIDTH-1]);
            cnt_d   = CNT_W'(WIDTH - 1);
            busy_d  = 1'b1;
            state_d = MD_ST_RUN;
         end
         MD_ST_RUN: begin
            busy_d = 1'b1;
            if (is_div) begin
               if (div_top >= {1'b0, b_q}) begin
                  work_d = {div_diff, work_q[WIDTH-2:0], 1'b1};
               end else begin
                  work_d = {div_top[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               work_d = {mul_sum, work_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
               state_d = MD_ST_FIX;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MD_ST_FIX: begin
            if (is_div) begin
               if (b_q == '0) begin
                  lo_d = WIDTH'(MD_DIVZ_LO);
                  hi_d = a_q;
               end else begin
                  lo_d = signfix(work_q[WIDTH-1:0], neg_q);
                  hi_d = signfix(work_q[W2-1:WIDTH], rsign_q);
               end
            end else begin
               hi_d = prod_fix[W2-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = MD_ST_DONE;
         end
         MD_ST_DONE: begin
            state_d = MD_ST_IDLE;
         end
         default: begin
            state_d = MD_ST_IDLE;
         end
      endcase
   end

   assign md_out_busy = busy_q;
   assign md_out_done = done_q;
   assign md_out_hi   = hi_q;
   assign md_out_lo   = lo_q;

endmodule

// File: tb/tb_mips_mult_div.sv
// Directed, table-driven bench for mips_mult_div.
module tb_mips_mult_div;
   import mips_mult_div_pkg::*;

   logic        md_in_clk = 1'b0;
   logic        md_in_rst;
   logic        md_in_start;
   logic [2:0]  md_in_op;
   logic [31:0] md_in_a;
   logic [31:0] md_in_b;
   logic        md_out_busy;
   logic        md_out_done;
   logic [31:0] md_out_hi;
   logic [31:0] md_out_lo;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          edges;
      int          busy;
   } vec_t;

   vec_t vecs[11];

   mips_mult_div #(.WIDTH(32)) dut (
      .md_in_clk  (md_in_clk),
      .md_in_rst  (md_in_rst),
      .md_in_start(md_in_start),
      .md_in_op   (md_in_op),
      .md_in_a    (md_in_a),
      .md_in_b    (md_in_b),
      .md_out_busy(md_out_busy),
      .md_out_done(md_out_done),
      .md_out_hi  (md_out_hi),
      .md_out_lo  (md_out_lo)
   );

   always #5 md_in_clk = ~md_in_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one op; count edges after the sampling edge until done, busy samples, and HI/LO stability.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busyn, output bit hold_ok);
      logic [31:0] hi0, lo0;
      @(negedge md_in_clk);
      md_in_start = 1'b1;
      md_in_op    = op;
      md_in_a     = a;
      md_in_b     = b;
      hi0         = md_out_hi;
      lo0         = md_out_lo;
      @(posedge md_in_clk);
      #1;
      md_in_start = 1'b0;
      md_in_a     = $urandom;
      md_in_b     = $urandom;
      edges   = 0;
      busyn   = 0;
      hold_ok = 1'b1;
      while (!md_out_done && edges < 60) begin
         if (md_out_busy) busyn++;
         if (md_out_hi !== hi0 || md_out_lo !== lo0) hold_ok = 1'b0;
         @(posedge md_in_clk);
         #1;
         edges++;
      end
   endtask

   initial begin
      int  edges, busyn, dcnt;
      bit  hold_ok;

      vecs[0]  = '{MD_OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 34, 34};
      vecs[1]  = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 34};
      vecs[2]  = '{MD_OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34, 34};
      vecs[3]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34};
      vecs[4]  = '{MD_OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 34, 34};
      vecs[5]  = '{MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, 34};
      vecs[6]  = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 34};
      vecs[7]  = '{MD_OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 34, 34};
      vecs[8]  = '{MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 34};
      vecs[9]  = '{MD_OP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD, 0,  0};
      vecs[10] = '{MD_OP_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0,  0};

      md_in_rst   = 1'b1;
      md_in_start = 1'b0;
      md_in_op    = '0;
      md_in_a     = '0;
      md_in_b     = '0;
      repeat (3) @(posedge md_in_clk);
      @(negedge md_in_clk);
      check("reset busy", 64'(md_out_busy), 64'd0);
      check("reset done", 64'(md_out_done), 64'd0);
      check("reset hi",   64'(md_out_hi),   64'd0);
      check("reset lo",   64'(md_out_lo),   64'd0);
      md_in_rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, busyn, hold_ok);
         check($sformatf("v%0d latency", i), 64'(edges), 64'(vecs[i].edges));
         check($sformatf("v%0d busy cycles", i), 64'(busyn), 64'(vecs[i].busy));
         check($sformatf("v%0d busy at done", i), 64'(md_out_busy), 64'd0);
         check($sformatf("v%0d hold", i), 64'(hold_ok), 64'd1);
         check($sformatf("v%0d hi", i), 64'(md_out_hi), 64'(vecs[i].hi));
         check($sformatf("v%0d lo", i), 64'(md_out_lo), 64'(vecs[i].lo));
         @(posedge md_in_clk);
         #1;
         check($sformatf("v%0d done one cycle", i), 64'(md_out_done), 64'd0);
      end

      // Back-to-back MTHI then MTLO: each accepted, done one cycle after each.
      @(negedge md_in_clk);
      md_in_start = 1'b1; md_in_op = MD_OP_MTHI; md_in_a = 32'hAAAA0001;
      @(posedge md_in_clk); #1;
      check("mthi done", 64'(md_out_done), 64'd1);
      check("mthi hi",   64'(md_out_hi),   64'hAAAA0001);
      @(negedge md_in_clk);
      md_in_op = MD_OP_MTLO; md_in_a = 32'hBBBB0002;
      @(posedge md_in_clk); #1;
      check("mtlo done", 64'(md_out_done), 64'd1);
      check("mtlo lo",   64'(md_out_lo),   64'hBBBB0002);
      check("mtlo hi kept", 64'(md_out_hi), 64'hAAAA0001);
      @(negedge md_in_clk);
      md_in_start = 1'b0;
      @(posedge md_in_clk); #1;
      check("mt done low", 64'(md_out_done), 64'd0);
      check("mt busy low", 64'(md_out_busy), 64'd0);

      // DIVU 10/3 with a second start at cycle 5 that must be ignored.
      @(negedge md_in_clk);
      md_in_start = 1'b1; md_in_op = MD_OP_DIVU; md_in_a = 32'd10; md_in_b = 32'd3;
      @(posedge md_in_clk); #1;
      md_in_start = 1'b0;
      repeat (4) @(posedge md_in_clk);
      @(negedge md_in_clk);
      md_in_start = 1'b1; md_in_op = MD_OP_MULT; md_in_a = 32'd7; md_in_b = 32'd9;
      @(posedge md_in_clk); #1;
      md_in_start = 1'b0;
      dcnt = 0;
      repeat (45) begin
         @(posedge md_in_clk); #1;
         if (md_out_done) dcnt++;
      end
      check("restart done count", 64'(dcnt), 64'd1);
      check("restart lo", 64'(md_out_lo), 64'd3);
      check("restart hi", 64'(md_out_hi), 64'd1);

      // Reset while a MULT is in flight.
      @(negedge md_in_clk);
      md_in_start = 1'b1; md_in_op = MD_OP_MULT; md_in_a = 32'h1234; md_in_b = 32'h55;
      @(posedge md_in_clk); #1;
      md_in_start = 1'b0;
      repeat (9) @(posedge md_in_clk);
      @(negedge md_in_clk);
      md_in_rst = 1'b1;
      @(posedge md_in_clk); #1;
      md_in_rst = 1'b0;
      check("rst busy", 64'(md_out_busy), 64'd0);
      check("rst done", 64'(md_out_done), 64'd0);
      check("rst hi",   64'(md_out_hi),   64'd0);
      check("rst lo",   64'(md_out_lo),   64'd0);
      dcnt = 0;
      repeat (40) begin
         @(posedge md_in_clk); #1;
         if (md_out_done) dcnt++;
      end
      check("rst no done", 64'(dcnt), 64'd0);
      do_op(MD_OP_MULTU, 32'd6, 32'd7, edges, busyn, hold_ok);
      check("post-rst latency", 64'(edges), 64'd34);
      check("post-rst lo", 64'(md_out_lo), 64'd42);
      check("post-rst hi", 64'(md_out_hi), 64'd0);

      // Reserved op codes are ignored.
      for (int r = 6; r < 8; r++) begin
         @(negedge md_in_clk);
         md_in_start = 1'b1; md_in_op = 3'(r); md_in_a = 32'hDEADBEEF;
         @(posedge md_in_clk); #1;
         md_in_start = 1'b0;
         dcnt = 0;
         busyn = 0;
         repeat (3) begin
            if (md_out_done) dcnt++;
            if (md_out_busy) busyn++;
            @(posedge md_in_clk); #1;
         end
         check($sformatf("rsv%0d done", r), 64'(dcnt), 64'd0);
         check($sformatf("rsv%0d busy", r), 64'(busyn), 64'd0);
         check($sformatf("rsv%0d lo", r), 64'(md_out_lo), 64'd42);
         check($sformatf("rsv%0d hi", r), 64'(md_out_hi), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
